// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: EX operand forwarding selects, load-use and multi-cycle scoreboard stalls.
// Forwarding and stall are combinational; scoreboard state and counters update on clk.
module hazard_scoreboard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int MC_SLOTS  = 2,
  parameter int LAT_W     = 6,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid_i,
  input  logic [NUM_SRC*5-1:0]     id_rs_addr_i,
  input  logic [NUM_SRC-1:0]       id_rs_used_i,
  input  logic                     ex_valid_i,
  input  logic                     ex_reg_write_i,
  input  logic                     ex_is_load_i,
  input  logic [4:0]               ex_rd_addr_i,
  input  logic [NUM_SRC*5-1:0]     ex_rs_addr_i,
  input  logic [FWD_DEPTH*5-1:0]   st_rd_addr_i,
  input  logic [FWD_DEPTH-1:0]     st_reg_write_i,
  input  logic                     mc_issue_i,
  input  logic [4:0]               mc_rd_addr_i,
  input  logic [LAT_W-1:0]         mc_lat_i,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
  output logic                     stall_o,
  output logic [MC_SLOTS-1:0]      mc_pending_o,
  output logic                     mc_full_o,
  output logic                     mc_overflow_o,
  output logic [15:0]              stall_count_o
);

  logic [MC_SLOTS-1:0]            valid_q, valid_d;
  logic [MC_SLOTS-1:0][4:0]       rd_q, rd_d;
  logic [MC_SLOTS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic                           overflow_q, overflow_d;
  logic [15:0]                    stall_count_q, stall_count_d;
  logic [MC_SLOTS-1:0]            alloc_oh;
  logic                           free_found;
  logic                           load_use_haz;
  logic                           sb_haz;
  logic [LAT_W-1:0]               eff_lat;

  // Scan from the highest stage down so the nearest matching stage wins.
  always_comb begin
    fwd_sel_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (st_reg_write_i[k] && (st_rd_addr_i[5*k +: 5] != 5'd0) &&
            (st_rd_addr_i[5*k +: 5] == ex_rs_addr_i[5*i +: 5])) begin
          fwd_sel_o[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    load_use_haz = 1'b0;
    sb_haz       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid_i && id_rs_used_i[i] && (id_rs_addr_i[5*i +: 5] != 5'd0)) begin
        if (ex_valid_i && ex_is_load_i && ex_reg_write_i &&
            (ex_rd_addr_i == id_rs_addr_i[5*i +: 5])) begin
          load_use_haz = 1'b1;
        end
        for (int j = 0; j < MC_SLOTS; j++) begin
          if (valid_q[j] && (rd_q[j] == id_rs_addr_i[5*i +: 5])) begin
            sb_haz = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o = load_use_haz | sb_haz;

  // Allocation looks only at the pre-edge free set, so a slot retiring this edge stays unused.
  always_comb begin
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int j = 0; j < MC_SLOTS; j++) begin
      if (!valid_q[j] && !free_found) begin
        alloc_oh[j] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign eff_lat = (mc_lat_i == '0) ? LAT_W'(1) : mc_lat_i;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    for (int j = 0; j < MC_SLOTS; j++) begin
      if (valid_q[j]) begin
        cnt_d[j] = cnt_q[j] - LAT_W'(1);
        if (cnt_q[j] == LAT_W'(1)) begin
          valid_d[j] = 1'b0;
        end
      end else if (mc_issue_i && (mc_rd_addr_i != 5'd0) && alloc_oh[j]) begin
        valid_d[j] = 1'b1;
        rd_d[j]    = mc_rd_addr_i;
        cnt_d[j]   = eff_lat;
      end
    end
    overflow_d    = overflow_q | (mc_issue_i && (mc_rd_addr_i != 5'd0) && !free_found);
    stall_count_d = (stall_o && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                             : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      valid_q       <= valid_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mc_pending_o  = valid_q;
  assign mc_full_o     = &valid_q;
  assign mc_overflow_o = overflow_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with default parameters.
module tb_hazard_scoreboard_unit;
  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic        ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd_addr;
  logic [9:0]  ex_rs_addr;
  logic [9:0]  st_rd_addr;
  logic [1:0]  st_reg_write;
  logic        mc_issue;
  logic [4:0]  mc_rd_addr;
  logic [5:0]  mc_lat;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [1:0]  mc_pending;
  logic        mc_full;
  logic        mc_overflow;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_addr_i  (id_rs_addr),
    .id_rs_used_i  (id_rs_used),
    .ex_valid_i    (ex_valid),
    .ex_reg_write_i(ex_reg_write),
    .ex_is_load_i  (ex_is_load),
    .ex_rd_addr_i  (ex_rd_addr),
    .ex_rs_addr_i  (ex_rs_addr),
    .st_rd_addr_i  (st_rd_addr),
    .st_reg_write_i(st_reg_write),
    .mc_issue_i    (mc_issue),
    .mc_rd_addr_i  (mc_rd_addr),
    .mc_lat_i      (mc_lat),
    .fwd_sel_o     (fwd_sel),
    .stall_o       (stall),
    .mc_pending_o  (mc_pending),
    .mc_full_o     (mc_full),
    .mc_overflow_o (mc_overflow),
    .stall_count_o (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0;
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd_addr = '0; ex_rs_addr = '0;
    st_rd_addr = '0; st_reg_write = '0;
    mc_issue = 0; mc_rd_addr = '0; mc_lat = '0;
    #3;
    check("rst_pending", 32'(mc_pending), 32'h0);
    check("rst_full", 32'(mc_full), 32'h0);
    check("rst_overflow", 32'(mc_overflow), 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // Forwarding priority
    st_rd_addr = {5'd5, 5'd5}; st_reg_write = 2'b11; ex_rs_addr = {5'd0, 5'd5}; #1;
    check("fwd_both_stages", 32'(fwd_sel), 32'h1);
    st_reg_write = 2'b10; #1;
    check("fwd_stage1_only", 32'(fwd_sel), 32'h2);
    st_rd_addr = '0; st_reg_write = 2'b11; ex_rs_addr = '0; #1;
    check("fwd_rd_zero", 32'(fwd_sel), 32'h0);
    st_rd_addr = {5'd3, 5'd5}; ex_rs_addr = {5'd3, 5'd5}; #1;
    check("fwd_two_sources", 32'(fwd_sel), 32'h9);
    st_rd_addr = '0; st_reg_write = '0; ex_rs_addr = '0;

    // Load-use, evaluated between edges
    ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd_addr = 5'd7;
    id_valid = 1; id_rs_addr = {5'd0, 5'd7}; id_rs_used = 2'b01; #1;
    check("loaduse_hit", 32'(stall), 32'h1);
    id_rs_used = 2'b10; #1;
    check("loaduse_unused", 32'(stall), 32'h0);
    id_rs_used = 2'b01; ex_is_load = 0; #1;
    check("loaduse_not_load", 32'(stall), 32'h0);
    ex_is_load = 1; ex_rd_addr = 5'd0; id_rs_addr = '0; #1;
    check("loaduse_x0", 32'(stall), 32'h0);
    ex_valid = 0; ex_is_load = 0; ex_reg_write = 0; ex_rd_addr = '0;
    tick();
    check("count_after_comb", 32'(stall_count), 32'h0);

    // Scoreboard countdown, rd=9 lat=3, consumed by source 1
    id_valid = 1; id_rs_addr = {5'd9, 5'd0}; id_rs_used = 2'b10;
    mc_issue = 1; mc_rd_addr = 5'd9; mc_lat = 6'd3; #1;
    check("sb_before_issue", 32'(stall), 32'h0);
    tick();
    mc_issue = 0;
    check("sb_pending", 32'(mc_pending), 32'h1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("sb_stall_cyc%0d", c), 32'(stall), 32'h1);
      tick();
    end
    check("sb_released", 32'(stall), 32'h0);
    check("sb_pending_clear", 32'(mc_pending), 32'h0);
    check("sb_stall_count", 32'(stall_count), 32'h3);

    // lat=0 acts as one cycle
    mc_issue = 1; mc_rd_addr = 5'd9; mc_lat = 6'd0;
    tick();
    mc_issue = 0;
    check("lat0_stall", 32'(stall), 32'h1);
    tick();
    check("lat0_released", 32'(stall), 32'h0);
    check("lat0_count", 32'(stall_count), 32'h4);

    // Issue to x0 does nothing
    mc_issue = 1; mc_rd_addr = 5'd0; mc_lat = 6'd5;
    tick();
    mc_issue = 0;
    check("rd0_no_alloc", 32'(mc_pending), 32'h0);
    check("rd0_no_overflow", 32'(mc_overflow), 32'h0);

    // Fill both entries, then overflow
    id_valid = 0;
    mc_issue = 1; mc_rd_addr = 5'd10; mc_lat = 6'd10;
    tick();
    check("fill1_pending", 32'(mc_pending), 32'h1);
    check("fill1_full", 32'(mc_full), 32'h0);
    mc_rd_addr = 5'd11;
    tick();
    check("fill2_pending", 32'(mc_pending), 32'h3);
    check("fill2_full", 32'(mc_full), 32'h1);
    check("fill2_no_overflow", 32'(mc_overflow), 32'h0);
    mc_rd_addr = 5'd12;
    tick();
    mc_issue = 0;
    check("ovf_flag", 32'(mc_overflow), 32'h1);
    check("ovf_pending", 32'(mc_pending), 32'h3);
    id_valid = 1; id_rs_addr = {5'd0, 5'd12}; id_rs_used = 2'b01; #1;
    check("ovf_dropped_no_stall", 32'(stall), 32'h0);
    id_rs_addr = {5'd0, 5'd11}; #1;
    check("sb_slot1_stall", 32'(stall), 32'h1);

    // Asynchronous reset mid-countdown
    #1 rst_n = 1'b0; #1;
    check("arst_pending", 32'(mc_pending), 32'h0);
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_overflow", 32'(mc_overflow), 32'h0);
    check("arst_count", 32'(stall_count), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", 32'(stall), 32'h0);
    check("post_rst_count", 32'(stall_count), 32'h0);

    // Saturation under a held load-use stall
    ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd_addr = 5'd7;
    id_rs_addr = {5'd0, 5'd7}; id_rs_used = 2'b01; #1;
    check("sat_stall_on", 32'(stall), 32'h1);
    repeat (65534) tick();
    check("sat_near", 32'(stall_count), 32'hFFFE);
    tick();
    check("sat_reached", 32'(stall_count), 32'hFFFF);
    repeat (4465) tick();
    check("sat_hold", 32'(stall_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
